// File: rtl/ma_acc_stage.sv
// Approximate accumulate stage: sums the upper operand field exactly and pins the low BORDER bits to a median pattern.
// Optional build macro MA_ACC_SATURATE_EN clamps the upper field on overflow and reports it on out_sat.
module ma_acc_stage #(
  parameter int BITWIDTH = 8,
  parameter int BORDER   = 2,
  parameter int LENGTH   = 4,
  parameter int ACCWIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITWIDTH-1:0]       in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACCWIDTH-1:0]       out_data,
  output logic [$clog2(LENGTH):0]   out_count,
  output logic                      out_sat
);

  // state  | meaning
  // S_ACC  | collecting beats, in_ready=1, no result pending
  // S_HOLD | result pending on out_*, in_ready follows out_ready

  localparam int UW  = ACCWIDTH - BORDER;
  localparam int CW  = $clog2(LENGTH) + 1;
  localparam int MED = ((1 << BORDER) >> 1) - ((BORDER > 0) ? 1 : 0);

  typedef enum logic {S_ACC, S_HOLD} state_t;
  typedef logic [UW-1:0] hi_t;
  typedef logic [CW-1:0] cnt_t;

  state_t                state_q, state_d;
  logic [ACCWIDTH-1:0]   acc_q;
  cnt_t                  cnt_q;
  logic                  sat_q;

  logic                  beat, res_acc, grp_done;
  hi_t                   base_hi, nxt_hi;
  cnt_t                  base_cnt, nxt_cnt;
  logic                  nxt_sat;
  logic                  unused_low;

  // low operand bits are approximated away and never reach the adder
  assign unused_low = ^in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grp_done)     state_d = S_HOLD;
    else if (res_acc) state_d = S_ACC;
  end

  always_comb begin
    out_valid = (state_q == S_HOLD);
    in_ready  = rst_n && ((state_q == S_ACC) || out_ready);
  end

  assign beat    = in_valid && in_ready;
  assign res_acc = out_valid && out_ready;

`ifdef MA_ACC_SATURATE_EN
  logic [UW:0] sum;
`endif

  // an accepted result means any same-cycle beat starts a fresh group
  always_comb begin
    base_hi  = res_acc ? '0 : acc_q[ACCWIDTH-1:BORDER];
    base_cnt = res_acc ? '0 : cnt_q;
    nxt_cnt  = base_cnt + cnt_t'(1);
`ifdef MA_ACC_SATURATE_EN
    sum      = {1'b0, base_hi} + {1'b0, hi_t'(in_data[BITWIDTH-1:BORDER])};
    nxt_sat  = (!res_acc && sat_q) || sum[UW];
    nxt_hi   = nxt_sat ? '1 : sum[UW-1:0];
`else
    nxt_sat  = 1'b0;
    nxt_hi   = base_hi + hi_t'(in_data[BITWIDTH-1:BORDER]);
`endif
    grp_done = beat && (in_last || (nxt_cnt == cnt_t'(LENGTH)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (beat) begin
      acc_q <= (ACCWIDTH'(nxt_hi) << BORDER) | ACCWIDTH'(MED);
      cnt_q <= nxt_cnt;
      sat_q <= nxt_sat;
    end else if (res_acc) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end
  end

  assign out_data  = acc_q;
  assign out_count = cnt_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_ma_acc_stage.sv
// Directed bench for ma_acc_stage: vector table on the default geometry plus reset and overflow sequences.
module tb_ma_acc_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_iv, a_ir, a_il, a_ov, a_or, a_sat;
  logic [7:0] a_id;
  logic [9:0] a_od;
  logic [2:0] a_oc;

  logic       b_iv, b_ir, b_il, b_ov, b_or, b_sat;
  logic [7:0] b_id;
  logic [8:0] b_od;
  logic [2:0] b_oc;

  ma_acc_stage #(.BITWIDTH(8), .BORDER(2), .LENGTH(4), .ACCWIDTH(10)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_last(a_il),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_count(a_oc), .out_sat(a_sat)
  );

  ma_acc_stage #(.BITWIDTH(8), .BORDER(2), .LENGTH(4), .ACCWIDTH(9)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_last(b_il),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_count(b_oc), .out_sat(b_sat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       ordy;
    logic       exp_irdy;
    logic       exp_ov;
    int         exp_od;
    int         exp_oc;
  } vec_t;

  vec_t vecs[27];

  task automatic drive_a(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    @(negedge clk);
    a_iv = v; a_id = d; a_il = l; a_or = ordy;
    #1;
  endtask

  task automatic check_a(input string tag, input logic ov, input int od, input int oc, input logic sat);
    chk({tag, "_out_valid"}, int'(a_ov), int'(ov));
    chk({tag, "_out_data"},  int'(a_od), od);
    chk({tag, "_out_count"}, int'(a_oc), oc);
    chk({tag, "_out_sat"},   int'(a_sat), int'(sat));
  endtask

  initial begin
    int exp_b_od;
    logic exp_b_sat;

    vecs = '{
      '{1, 4,   0, 1, 1, 0, 5,   1},
      '{1, 8,   0, 1, 1, 0, 13,  2},
      '{1, 12,  0, 1, 1, 0, 25,  3},
      '{1, 16,  0, 1, 1, 1, 41,  4},
      '{0, 0,   0, 1, 1, 0, 0,   0},
      '{1, 20,  0, 1, 1, 0, 21,  1},
      '{1, 24,  1, 1, 1, 1, 45,  2},
      '{0, 0,   0, 0, 0, 1, 45,  2},
      '{1, 99,  1, 0, 0, 1, 45,  2},
      '{0, 0,   1, 1, 1, 0, 0,   0},
      '{0, 0,   1, 1, 1, 0, 0,   0},
      '{1, 4,   0, 1, 1, 0, 5,   1},
      '{1, 8,   0, 1, 1, 0, 13,  2},
      '{1, 12,  0, 1, 1, 0, 25,  3},
      '{1, 16,  0, 1, 1, 1, 41,  4},
      '{0, 0,   0, 0, 0, 1, 41,  4},
      '{1, 200, 0, 0, 0, 1, 41,  4},
      '{0, 0,   0, 0, 0, 1, 41,  4},
      '{1, 36,  0, 1, 1, 0, 37,  1},
      '{1, 40,  1, 1, 1, 1, 77,  2},
      '{1, 8,   1, 1, 1, 1, 9,   1},
      '{0, 0,   0, 1, 1, 0, 0,   0},
      '{1, 7,   0, 1, 1, 0, 5,   1},
      '{1, 3,   0, 1, 1, 0, 5,   2},
      '{1, 255, 0, 1, 1, 0, 257, 3},
      '{1, 255, 0, 1, 1, 1, 509, 4},
      '{0, 0,   0, 1, 1, 0, 0,   0}
    };

`ifdef MA_ACC_SATURATE_EN
    exp_b_od  = 509;
    exp_b_sat = 1'b1;
`else
    exp_b_od  = 497;
    exp_b_sat = 1'b0;
`endif

    rst_n = 1'b0;
    a_iv = 1'b0; a_id = '0; a_il = 1'b0; a_or = 1'b0;
    b_iv = 1'b0; b_id = '0; b_il = 1'b0; b_or = 1'b1;

    // reset: in_ready low while held, outputs cleared after the edge
    drive_a(1'b1, 8'd4, 1'b0, 1'b1);
    chk("reset_in_ready", int'(a_ir), 0);
    @(posedge clk); #1;
    check_a("reset", 1'b0, 0, 0, 1'b0);
    drive_a(1'b0, 8'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      a_iv = vecs[i].v; a_id = vecs[i].d; a_il = vecs[i].l; a_or = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", i), int'(a_ir), int'(vecs[i].exp_irdy));
      @(posedge clk); #1;
      check_a($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_oc, 1'b0);
    end

    // partial group discarded by a one-cycle reset
    drive_a(1'b1, 8'd4, 1'b0, 1'b1);
    @(posedge clk);
    drive_a(1'b1, 8'd8, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_a("midrst_pre", 1'b0, 13, 2, 1'b0);
    drive_a(1'b1, 8'd12, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(a_ir), 0);
    @(posedge clk); #1;
    check_a("midrst", 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a_iv = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_a(1'b1, 8'(4 * i), 1'b0, 1'b1);
      @(posedge clk); #1;
    end
    check_a("midrst_group", 1'b1, 41, 4, 1'b0);
    drive_a(1'b0, 8'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_a("midrst_accept", 1'b0, 0, 0, 1'b0);

    // overflow on the 9-bit accumulator
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_iv = 1'b1; b_id = 8'd255; b_il = 1'b0; b_or = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    b_iv = 1'b0;
    #1;
    chk("ovf_out_valid", int'(b_ov), 1);
    chk("ovf_out_data",  int'(b_od), exp_b_od);
    chk("ovf_out_count", int'(b_oc), 4);
    chk("ovf_out_sat",   int'(b_sat), int'(exp_b_sat));
    chk("ovf_in_ready",  int'(b_ir), 0);
    b_or = 1'b1;
    @(posedge clk); #1;
    chk("ovf_accept_valid", int'(b_ov), 0);
    chk("ovf_accept_data",  int'(b_od), 0);
    chk("ovf_accept_sat",   int'(b_sat), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
